// File: rtl/alk_mdseq_pkg.sv
// Shared types for the ALK MUL/DIV step sequencer: state encoding, default
// sizing and the per-state step control decode.
package alk_mdseq_pkg;

    localparam int STEPS_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef struct packed {
        logic mul_group;
        logic divdbl_l;
        logic shl;
        logic shr;
        logic add;
        logic sub;
        logic busy;
        logic stall_l;
        logic done;
    } step_ctl_t;

    // The MUL add is left 0 here; the top muxes in the live ALUF flag.
    function automatic step_ctl_t decode_step(input state_t st, input logic qs);
        step_ctl_t c;
        c.mul_group = 1'b0;
        c.divdbl_l  = 1'b1;
        c.shl       = 1'b0;
        c.shr       = 1'b0;
        c.add       = 1'b0;
        c.sub       = 1'b0;
        c.busy      = 1'b1;
        c.stall_l   = 1'b0;
        c.done      = 1'b0;
        case (st)
            ST_IDLE: begin
                c.busy    = 1'b0;
                c.stall_l = 1'b1;
            end
            ST_MUL: begin
                c.mul_group = 1'b1;
                c.shr       = 1'b1;
            end
            ST_DIV: begin
                c.divdbl_l = 1'b0;
                c.shl      = 1'b1;
                c.add      = qs;
                c.sub      = ~qs;
            end
            ST_FIX: begin
                c.divdbl_l = 1'b0;
                c.add      = qs;
            end
            ST_DONE: begin
                c.done = 1'b1;
            end
            default: begin
                c.busy    = 1'b0;
                c.stall_l = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alkmdseq_cnt.sv
// alkmdcnt: loadable step down-counter with zero detect. Priority is
// reset, clear, load, decrement.
module alkmdcnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Count register.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/alkmdseq.sv
// ALK MUL/DIV step sequencer driving the ALPCTL mul/div and shift controls.
// Define ALK_MDSEQ_FIX_EN to include the hardware divide-remainder fix cycle.
module alkmdseq
    import alk_mdseq_pkg::*;
#(
    parameter int STEPS = STEPS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             qdclk_l,
    input  logic             reset_h,
    input  logic             mul_start_h,
    input  logic             div_start_h,
    input  logic             abort_h,
    input  logic             aluso_flag_h,
    input  logic             alu_sign_h,
    output logic             alpctl_mul_group_h,
    output logic             alpctl_divdbl_l,
    output logic             alpctl_shl_op_h,
    output logic             alpctl_shr_op_h,
    output logic             step_add_h,
    output logic             step_sub_h,
    output logic             busy_h,
    output logic             stall_l,
    output logic             done_h,
    output logic [CNT_W-1:0] step_cnt_h
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(STEPS - 1);

    state_t    state_r;
    state_t    state_nxt_s;
    logic      qs_r;
    logic      qs_nxt_s;
    step_ctl_t ctl_r;
    logic      cnt_load_s;
    logic      cnt_dec_s;
    logic      cnt_clr_s;
    logic      cnt_zero_s;

    alkmdcnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (qdclk_l),
        .srst     (reset_h),
        .load     (cnt_load_s),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec_s),
        .clr      (cnt_clr_s),
        .count    (step_cnt_h),
        .zero     (cnt_zero_s)
    );

    // Next-state, quotient-sign and counter control.
    always_comb begin
        state_nxt_s = state_r;
        qs_nxt_s    = qs_r;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        cnt_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                qs_nxt_s = 1'b0;
                if (mul_start_h) begin
                    state_nxt_s = ST_MUL;
                    cnt_load_s  = 1'b1;
                end else if (div_start_h) begin
                    state_nxt_s = ST_DIV;
                    cnt_load_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                cnt_dec_s = ~cnt_zero_s;
                if (cnt_zero_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            ST_DIV: begin
                qs_nxt_s  = alu_sign_h;
                cnt_dec_s = ~cnt_zero_s;
                if (cnt_zero_s) begin
`ifdef ALK_MDSEQ_FIX_EN
                    // A clear sign needs no correction, so FIX is skipped entirely.
                    state_nxt_s = alu_sign_h ? ST_FIX : ST_DONE;
`else
                    state_nxt_s = ST_DONE;
`endif
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_FIX: begin
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_clr_s   = 1'b1;
            end
        endcase
        if (abort_h && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_IDLE;
            qs_nxt_s    = 1'b0;
            cnt_load_s  = 1'b0;
            cnt_dec_s   = 1'b0;
            cnt_clr_s   = 1'b1;
        end else begin
            cnt_clr_s = cnt_clr_s;
        end
    end

    // State, quotient sign and registered step-control decode of the next state.
    always_ff @(posedge qdclk_l) begin
        if (reset_h) begin
            state_r <= ST_IDLE;
            qs_r    <= 1'b0;
            ctl_r   <= decode_step(ST_IDLE, 1'b0);
        end else begin
            state_r <= state_nxt_s;
            qs_r    <= qs_nxt_s;
            ctl_r   <= decode_step(state_nxt_s, qs_nxt_s);
        end
    end

    assign alpctl_mul_group_h = ctl_r.mul_group;
    assign alpctl_divdbl_l    = ctl_r.divdbl_l;
    assign alpctl_shl_op_h    = ctl_r.shl;
    assign alpctl_shr_op_h    = ctl_r.shr;
    // ALUF flag is a flop, so this MUL-only path stays flop-to-flop.
    assign step_add_h         = ctl_r.mul_group ? aluso_flag_h : ctl_r.add;
    assign step_sub_h         = ctl_r.sub;
    assign busy_h             = ctl_r.busy;
    assign stall_l            = ctl_r.stall_l;
    assign done_h             = ctl_r.done;

endmodule

// File: tb/tb_alkmdseq.sv
// Scoreboard bench for alkmdseq: stimulus queues the expected output vector
// for each cycle, a negedge monitor pops and compares.
module tb_alkmdseq;

    logic       qdclk_l = 1'b0;
    logic       reset_h = 1'b1;
    logic       mul_start_h = 1'b0;
    logic       div_start_h = 1'b0;
    logic       abort_h = 1'b0;
    logic       aluso_flag_h = 1'b0;
    logic       alu_sign_h = 1'b0;
    logic       alpctl_mul_group_h, alpctl_divdbl_l, alpctl_shl_op_h, alpctl_shr_op_h;
    logic       step_add_h, step_sub_h, busy_h, stall_l, done_h;
    logic [5:0] step_cnt_h;

    typedef struct {
        string       tag;
        logic [14:0] v;
    } exp_t;

    exp_t   sb[$];
    integer checks = 0;
    integer errors = 0;

    alkmdseq #(.STEPS(32), .CNT_W(6)) dut (
        .qdclk_l            (qdclk_l),
        .reset_h            (reset_h),
        .mul_start_h        (mul_start_h),
        .div_start_h        (div_start_h),
        .abort_h            (abort_h),
        .aluso_flag_h       (aluso_flag_h),
        .alu_sign_h         (alu_sign_h),
        .alpctl_mul_group_h (alpctl_mul_group_h),
        .alpctl_divdbl_l    (alpctl_divdbl_l),
        .alpctl_shl_op_h    (alpctl_shl_op_h),
        .alpctl_shr_op_h    (alpctl_shr_op_h),
        .step_add_h         (step_add_h),
        .step_sub_h         (step_sub_h),
        .busy_h             (busy_h),
        .stall_l            (stall_l),
        .done_h             (done_h),
        .step_cnt_h         (step_cnt_h)
    );

    always #5 qdclk_l = ~qdclk_l;

    function automatic logic [14:0] mk(input logic mg, input logic dd, input logic sl,
                                       input logic sr, input logic ad, input logic su,
                                       input logic bz, input logic dn, input logic [5:0] c);
        return {mg, dd, sl, sr, ad, su, bz, ~bz, dn, c};
    endfunction

    localparam logic [14:0] IDLE_V = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0};
    localparam logic [14:0] DONE_V = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0};

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge qdclk_l) begin
        logic [14:0] act;
        exp_t        e;
        act = {alpctl_mul_group_h, alpctl_divdbl_l, alpctl_shl_op_h, alpctl_shr_op_h,
               step_add_h, step_sub_h, busy_h, stall_l, done_h, step_cnt_h};
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks = checks + 1;
            if (act !== e.v) begin
                errors = errors + 1;
                $display("FAIL %s at %0t: got %h want %h", e.tag, $time, act, e.v);
            end
        end else if (busy_h === 1'b1) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_busy at %0t: got busy %b want 0", $time, busy_h);
        end
    end

    task automatic cyc(input logic [14:0] v, input string tag);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
        @(posedge qdclk_l);
        #1;
    endtask

    task automatic start_op(input logic m, input logic d);
        mul_start_h = m;
        div_start_h = d;
        cyc(IDLE_V, "start_cycle");
        mul_start_h = 1'b0;
        div_start_h = 1'b0;
    endtask

    // MUL steps with flag 1010...; a start at step 5 must be ignored.
    task automatic mul_steps(input int abort_at);
        logic f;
        for (int i = 0; i < 32; i++) begin
            f = (i % 2 == 0) ? 1'b1 : 1'b0;
            aluso_flag_h = f;
            div_start_h  = (i == 5) ? 1'b1 : 1'b0;
            mul_start_h  = (i == 5) ? 1'b1 : 1'b0;
            abort_h      = (i == abort_at) ? 1'b1 : 1'b0;
            cyc(mk(1'b1, 1'b1, 1'b0, 1'b1, f, 1'b0, 1'b1, 1'b0, 6'(31 - i)), "mul_step");
            if (i == abort_at) begin
                abort_h = 1'b0;
                aluso_flag_h = 1'b0;
                cyc(IDLE_V, "abort_idle");
                return;
            end
        end
        abort_h = 1'b0;
        aluso_flag_h = 1'b0;
        div_start_h = 1'b0;
        mul_start_h = 1'b1;
        cyc(DONE_V, "mul_done");
        mul_start_h = 1'b0;
        cyc(IDLE_V, "start_in_done_ignored");
    endtask

    function automatic logic sign_at(input int pat, input int i);
        if (pat == 0) return (i % 3 == 1) || (i == 31);
        else return (i % 4 == 0);
    endfunction

    task automatic div_steps(input int pat);
        logic prev;
        prev = 1'b0;
        for (int i = 0; i < 32; i++) begin
            alu_sign_h = sign_at(pat, i);
            cyc(mk(1'b0, 1'b0, 1'b1, 1'b0, prev, ~prev, 1'b1, 1'b0, 6'(31 - i)), "div_step");
            prev = sign_at(pat, i);
        end
        alu_sign_h = 1'b0;
`ifdef ALK_MDSEQ_FIX_EN
        if (prev) begin
            cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0), "div_fix");
        end
`endif
        cyc(DONE_V, "div_done");
        cyc(IDLE_V, "div_post");
    endtask

    initial begin
        @(posedge qdclk_l);
        #1;
        cyc(IDLE_V, "reset_state");
        cyc(IDLE_V, "reset_state");
        reset_h = 1'b0;
        repeat (3) cyc(IDLE_V, "idle_after_reset");

        start_op(1'b1, 1'b0);
        mul_steps(-1);

        start_op(1'b0, 1'b1);
        div_steps(0);

        start_op(1'b1, 1'b1);
        mul_steps(10);
        cyc(IDLE_V, "idle_gap");
        start_op(1'b0, 1'b1);
        div_steps(1);

        start_op(1'b1, 1'b0);
        mul_steps(31);
        repeat (2) cyc(IDLE_V, "idle_tail");

        @(negedge qdclk_l);
        #1;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
